// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-cycle word RAM, with a bounded burst hold window.
// Grant and accept are combinational (0 cycles); read data returns 1 cycle after acceptance; a RAM stall holds the grant in place.
module ram_port_arbiter #(
  parameter int BURST_HOLD = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  p0_wr_i,
  input  logic        p0_rd_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_write_data_i,
  output logic        p0_accept_o,
  output logic [31:0] p0_read_data_o,
  input  logic [3:0]  p1_wr_i,
  input  logic        p1_rd_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_write_data_i,
  output logic        p1_accept_o,
  output logic [31:0] p1_read_data_o,
  output logic [3:0]  ram_wr_o,
  output logic        ram_rd_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_write_data_o,
  input  logic        ram_accept_i,
  input  logic [31:0] ram_read_data_i
);

  localparam logic [3:0] HOLD_LIMIT = 4'(BURST_HOLD);

  logic        owner_q;
  logic [3:0]  hold_cnt_q;
  logic        rd_pend_q;
  logic        rd_port_q;
  logic [31:0] hold0_q;
  logic [31:0] hold1_q;

  logic        req0;
  logic        req1;
  logic        any_req;
  logic        win;
  logic        acc;
  logic        rd_acc;
  logic [3:0]  sel_wr;
  logic        sel_rd;

  assign req0 = p0_rd_i | (p0_wr_i != 4'b0);
  assign req1 = p1_rd_i | (p1_wr_i != 4'b0);

  // No grant while reset is held, so nothing is accepted that the state cannot record.
  assign any_req = rst_i & (req0 | req1);

  // Winner defaults to port 0 so the idle mux presents port 0.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = (hold_cnt_q < HOLD_LIMIT) ? owner_q : ~owner_q;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  assign sel_wr = win ? p1_wr_i : p0_wr_i;
  assign sel_rd = win ? p1_rd_i : p0_rd_i;

  assign ram_wr_o         = any_req ? sel_wr : 4'b0;
  assign ram_rd_o         = any_req & sel_rd;
  assign ram_addr_o       = win ? p1_addr_i : p0_addr_i;
  assign ram_write_data_o = win ? p1_write_data_i : p0_write_data_i;

  assign acc         = any_req & ram_accept_i;
  assign p0_accept_o = acc & ~win;
  assign p1_accept_o = acc & win;

  // A beat carrying both read and write strobes is a write and returns nothing.
  assign rd_acc = acc & sel_rd & (sel_wr == 4'b0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q    <= 1'b1;
      hold_cnt_q <= HOLD_LIMIT;
    end else if (acc) begin
      if (win == owner_q) begin
        if (hold_cnt_q != 4'hF) begin
          hold_cnt_q <= hold_cnt_q + 4'd1;
        end
      end else begin
        owner_q    <= win;
        hold_cnt_q <= 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
      hold0_q   <= 32'b0;
      hold1_q   <= 32'b0;
    end else begin
      rd_pend_q <= rd_acc;
      if (rd_acc) begin
        rd_port_q <= win;
      end
      if (rd_pend_q) begin
        if (rd_port_q) begin
          hold1_q <= ram_read_data_i;
        end else begin
          hold0_q <= ram_read_data_i;
        end
      end
    end
  end

  assign p0_read_data_o = (rd_pend_q && !rd_port_q) ? ram_read_data_i : hold0_q;
  assign p1_read_data_o = (rd_pend_q &&  rd_port_q) ? ram_read_data_i : hold1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances (hold window 4 and 1) share stimulus and are scored against a port-level model.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  p0_wr, p1_wr;
  logic        p0_rd, p1_rd;
  logic [31:0] p0_addr, p1_addr, p0_wd, p1_wd;
  logic        ram_accept;
  logic [31:0] ram_rdata;

  logic        p0_acc [2];
  logic        p1_acc [2];
  logic [31:0] p0_rdat [2];
  logic [31:0] p1_rdat [2];
  logic [3:0]  ram_wr [2];
  logic        ram_rd [2];
  logic [31:0] ram_addr [2];
  logic [31:0] ram_wdat [2];

  ram_port_arbiter #(.BURST_HOLD(4)) u_hold4 (
    .clk_i(clk), .rst_i(rst_n),
    .p0_wr_i(p0_wr), .p0_rd_i(p0_rd), .p0_addr_i(p0_addr), .p0_write_data_i(p0_wd),
    .p0_accept_o(p0_acc[0]), .p0_read_data_o(p0_rdat[0]),
    .p1_wr_i(p1_wr), .p1_rd_i(p1_rd), .p1_addr_i(p1_addr), .p1_write_data_i(p1_wd),
    .p1_accept_o(p1_acc[0]), .p1_read_data_o(p1_rdat[0]),
    .ram_wr_o(ram_wr[0]), .ram_rd_o(ram_rd[0]), .ram_addr_o(ram_addr[0]),
    .ram_write_data_o(ram_wdat[0]), .ram_accept_i(ram_accept), .ram_read_data_i(ram_rdata)
  );

  ram_port_arbiter #(.BURST_HOLD(1)) u_hold1 (
    .clk_i(clk), .rst_i(rst_n),
    .p0_wr_i(p0_wr), .p0_rd_i(p0_rd), .p0_addr_i(p0_addr), .p0_write_data_i(p0_wd),
    .p0_accept_o(p0_acc[1]), .p0_read_data_o(p0_rdat[1]),
    .p1_wr_i(p1_wr), .p1_rd_i(p1_rd), .p1_addr_i(p1_addr), .p1_write_data_i(p1_wd),
    .p1_accept_o(p1_acc[1]), .p1_read_data_o(p1_rdat[1]),
    .ram_wr_o(ram_wr[1]), .ram_rd_o(ram_rd[1]), .ram_addr_o(ram_addr[1]),
    .ram_write_data_o(ram_wdat[1]), .ram_accept_i(ram_accept), .ram_read_data_i(ram_rdata)
  );

  int errors = 0;
  int checks = 0;

  // Model: who owns the RAM, how long its current streak is, and which port awaits a read word.
  int          last_port [2];
  int          streak [2];
  bit          pend [2];
  int          pend_port [2];
  logic [31:0] held [2][2];

  function automatic int hold_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int winner(input int k);
    bit r0, r1;
    r0 = p0_rd | (p0_wr != 4'b0);
    r1 = p1_rd | (p1_wr != 4'b0);
    if (!rst_n) return -1;
    if (r0 && r1) return (streak[k] < hold_of(k)) ? last_port[k] : 1 - last_port[k];
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_port[k] = 1;
      streak[k]    = hold_of(k);
      pend[k]      = 1'b0;
      pend_port[k] = 0;
      held[k][0]   = 32'b0;
      held[k][1]   = 32'b0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      int w;
      bit accd, newpend;
      logic [3:0] wstb;
      logic rdb;
      w = winner(k);
      accd = (w >= 0) && ram_accept;
      wstb = (w == 1) ? p1_wr : p0_wr;
      rdb  = (w == 1) ? p1_rd : p0_rd;
      if (pend[k]) held[k][pend_port[k]] = ram_rdata;
      newpend = accd && rdb && (wstb == 4'b0);
      if (accd) begin
        if (w == last_port[k]) streak[k] = (streak[k] < 15) ? streak[k] + 1 : 15;
        else begin
          last_port[k] = w;
          streak[k]    = 1;
        end
      end
      if (newpend) pend_port[k] = w;
      pend[k] = newpend;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int w;
      logic [31:0] e0, e1;
      w = winner(k);
      e0 = (pend[k] && pend_port[k] == 0) ? ram_rdata : held[k][0];
      e1 = (pend[k] && pend_port[k] == 1) ? ram_rdata : held[k][1];
      chk($sformatf("u%0d_p0_accept", k), 32'(p0_acc[k]), 32'((w == 0) && ram_accept));
      chk($sformatf("u%0d_p1_accept", k), 32'(p1_acc[k]), 32'((w == 1) && ram_accept));
      chk($sformatf("u%0d_ram_wr", k), 32'(ram_wr[k]), (w < 0) ? 32'd0 : 32'((w == 1) ? p1_wr : p0_wr));
      chk($sformatf("u%0d_ram_rd", k), 32'(ram_rd[k]), (w < 0) ? 32'd0 : 32'((w == 1) ? p1_rd : p0_rd));
      chk($sformatf("u%0d_ram_addr", k), ram_addr[k], (w == 1) ? p1_addr : p0_addr);
      chk($sformatf("u%0d_ram_wdata", k), ram_wdat[k], (w == 1) ? p1_wd : p0_wd);
      chk($sformatf("u%0d_p0_rdata", k), p0_rdat[k], e0);
      chk($sformatf("u%0d_p1_rdata", k), p1_rdat[k], e1);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_clock();
    #1;
  endtask

  task automatic drive(input logic [3:0] w0, input logic r0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic [3:0] w1, input logic r1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic acc, input logic [31:0] rdat);
    p0_wr = w0; p0_rd = r0; p0_addr = a0; p0_wd = d0;
    p1_wr = w1; p1_rd = r1; p1_addr = a1; p1_wd = d1;
    ram_accept = acc; ram_rdata = rdat;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    drive(4'h0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'h5555_AAAA);
    sample();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Reset then idle.
    do_reset();
    sample();
    chk("idle_ram_rd", 32'(ram_rd[0]), 32'd0);
    chk("idle_p1_rdata", p1_rdat[0], 32'd0);
    tick();

    // Single read from port 0.
    drive(4'h0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1111_2222);
    sample();
    chk("rd0_accept", 32'(p0_acc[0]), 32'd1);
    tick();
    drive(4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    sample();
    chk("rd0_return", p0_rdat[0], 32'hDEAD_BEEF);
    chk("rd0_p1_untouched", p1_rdat[0], 32'd0);
    tick();
    ram_rdata = 32'h0BAD_F00D;
    sample();
    chk("rd0_held", p0_rdat[0], 32'hDEAD_BEEF);
    tick();

    // Both ports bursting reads.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(4'h0, 1'b1, 32'h1000 + 32'(i), 32'h0, 4'h0, 1'b1, 32'h2000 + 32'(i), 32'h0, 1'b1, $urandom);
      sample();
      chk($sformatf("burst4_p0_acc_%0d", i), 32'(p0_acc[0]), 32'(((i / 4) % 2) == 0));
      chk($sformatf("burst1_p0_acc_%0d", i), 32'(p0_acc[1]), 32'((i % 2) == 0));
      chk($sformatf("burst1_one_acc_%0d", i), 32'(p0_acc[1] & p1_acc[1]), 32'd0);
      tick();
    end
    drive(4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1, $urandom);
    sample();
    tick();

    // Stalled write from port 0 while port 1 waits.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(4'hF, 1'b0, 32'h40, 32'h1234_5678, 4'h0, 1'b1, 32'h80, 32'h0, (i == 3), $urandom);
      sample();
      chk($sformatf("stall_wr_%0d", i), 32'(ram_wr[0]), 32'hF);
      chk($sformatf("stall_addr_%0d", i), ram_addr[0], 32'h40);
      chk($sformatf("stall_p0_acc_%0d", i), 32'(p0_acc[0]), 32'(i == 3));
      tick();
    end

    // Reset lands between a port 1 read and its return.
    do_reset();
    drive(4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h200, 32'h0, 1'b1, 32'h0);
    sample();
    chk("mid_p1_acc", 32'(p1_acc[0]), 32'd1);
    tick();
    rst_n = 1'b0;
    model_reset();
    drive(4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFE_F00D);
    sample();
    chk("mid_p1_rdata", p1_rdat[0], 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'h0, 1'b1, 32'h300, 32'h0, 4'h0, 1'b1, 32'h400, 32'h0, 1'b1, 32'h0);
    sample();
    chk("post_rst_tie_u0", 32'(p0_acc[0]), 32'd1);
    chk("post_rst_tie_u1", 32'(p0_acc[1]), 32'd1);
    tick();

    // Random traffic with stalls and mixed read/write beats.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, 1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, 1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 3) != 0), $urandom);
      sample();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
